// File: rtl/tlc_mon_pkg.sv
// rtl/tlc_mon_pkg.sv - shared types, fault codes and lamp decode for the conflict monitor
package tlc_mon_pkg;

    typedef enum logic [2:0] {
        ASP_OFF,
        ASP_G,
        ASP_Y,
        ASP_R,
        ASP_MULTI
    } aspect_t;

    typedef enum logic {
        MON_NORMAL,
        MON_FLASH
    } mon_state_t;

    localparam logic [2:0] FC_NONE         = 3'd0;
    localparam logic [2:0] FC_CONFLICT     = 3'd1;
    localparam logic [2:0] FC_MULTI        = 3'd2;
    localparam logic [2:0] FC_DARK         = 3'd3;
    localparam logic [2:0] FC_SEQUENCE     = 3'd4;
    localparam logic [2:0] FC_SHORT_YELLOW = 3'd5;

    function automatic aspect_t decode_aspect(input logic g, input logic y, input logic r);
        case ({r, y, g})
            3'b000:  return ASP_OFF;
            3'b001:  return ASP_G;
            3'b010:  return ASP_Y;
            3'b100:  return ASP_R;
            default: return ASP_MULTI;
        endcase
    endfunction

endpackage

// File: rtl/tlc_dir_checker.sv
// rtl/tlc_dir_checker.sv - per-approach aspect decode, history and dwell/dark checks
module tlc_dir_checker
    import tlc_mon_pkg::*;
#(
    parameter int DARK_LIMIT = 4,
    parameter int MIN_YELLOW = 3
) (
    input  logic       clk,
    input  logic       rst_a,
    input  logic [2:0] green,
    input  logic [2:0] yellow,
    input  logic [2:0] red,
    output logic       flag_multi,
    output logic       flag_dark,
    output logic       flag_sequence,
    output logic       flag_short_yellow
);

    localparam int DW = $clog2(DARK_LIMIT + 1);
    localparam int YW = $clog2(MIN_YELLOW + 1);

    aspect_t        aspect;
    aspect_t        last_q;
    logic [DW-1:0]  dark_q;
    logic [YW-1:0]  yel_q;
    logic           single;
    logic           legal_step;

    assign aspect = decode_aspect(|green, |yellow, |red);
    assign single = (aspect == ASP_G) || (aspect == ASP_Y) || (aspect == ASP_R);

    always_comb begin
        legal_step = 1'b0;
        case (last_q)
            ASP_G:   legal_step = (aspect == ASP_Y);
            ASP_Y:   legal_step = (aspect == ASP_R);
            ASP_R:   legal_step = (aspect == ASP_G);
            default: legal_step = 1'b0;
        endcase
    end

    // History is the last single-lamp aspect, so dark gaps do not erase it.
    assign flag_multi        = (aspect == ASP_MULTI);
    assign flag_dark         = (aspect == ASP_OFF) && (dark_q >= DW'(DARK_LIMIT - 1));
    assign flag_sequence     = single && (aspect != last_q) && !legal_step;
    assign flag_short_yellow = (last_q == ASP_Y) && (aspect == ASP_R) && (yel_q < YW'(MIN_YELLOW));

    always_ff @(posedge clk) begin
        if (rst_a) begin
            last_q <= ASP_R;
            dark_q <= '0;
            yel_q  <= '0;
        end else begin
            if (aspect == ASP_OFF) begin
                if (dark_q != DW'(DARK_LIMIT))
                    dark_q <= dark_q + DW'(1);
            end else begin
                dark_q <= '0;
            end

            if (aspect == ASP_Y) begin
                if (last_q != ASP_Y)
                    yel_q <= YW'(1);
                else if (yel_q < YW'(MIN_YELLOW))
                    yel_q <= yel_q + YW'(1);
            end

            if (single)
                last_q <= aspect;
        end
    end

endmodule

// File: rtl/tlc_conflict_monitor.sv
// rtl/tlc_conflict_monitor.sv - registered lamp forwarder that latches the first violation and flashes red
module tlc_conflict_monitor
    import tlc_mon_pkg::*;
#(
    parameter int DARK_LIMIT = 4,
    parameter int MIN_YELLOW = 3,
    parameter int FLASH_HALF = 8
) (
    input  logic       clk,
    input  logic       rst_a,
    input  logic [2:0] green_ns,
    input  logic [2:0] yellow_ns,
    input  logic [2:0] red_ns,
    input  logic [2:0] green_ew,
    input  logic [2:0] yellow_ew,
    input  logic [2:0] red_ew,
    output logic [2:0] lamp_ns,
    output logic [2:0] lamp_ew,
    output logic       fault,
    output logic [2:0] fault_code
);

    localparam int FW = $clog2(FLASH_HALF + 1);

    logic ns_multi, ns_dark, ns_seq, ns_short;
    logic ew_multi, ew_dark, ew_seq, ew_short;
    logic conflict;
    logic [2:0] code;
    mon_state_t state_q, state_d;
    logic [FW-1:0] flash_cnt_q;
    logic flash_on_q;
    logic flash_wrap;

    tlc_dir_checker #(.DARK_LIMIT(DARK_LIMIT), .MIN_YELLOW(MIN_YELLOW)) u_ns (
        .clk(clk), .rst_a(rst_a),
        .green(green_ns), .yellow(yellow_ns), .red(red_ns),
        .flag_multi(ns_multi), .flag_dark(ns_dark),
        .flag_sequence(ns_seq), .flag_short_yellow(ns_short)
    );

    tlc_dir_checker #(.DARK_LIMIT(DARK_LIMIT), .MIN_YELLOW(MIN_YELLOW)) u_ew (
        .clk(clk), .rst_a(rst_a),
        .green(green_ew), .yellow(yellow_ew), .red(red_ew),
        .flag_multi(ew_multi), .flag_dark(ew_dark),
        .flag_sequence(ew_seq), .flag_short_yellow(ew_short)
    );

    // Raw lamp bits, so a G/Y approach that is also MULTI still reports as a conflict.
    assign conflict = ((|green_ns) || (|yellow_ns)) && ((|green_ew) || (|yellow_ew));

    always_comb begin
        code = FC_NONE;
        if (conflict)                  code = FC_CONFLICT;
        else if (ns_multi || ew_multi) code = FC_MULTI;
        else if (ns_dark  || ew_dark)  code = FC_DARK;
        else if (ns_seq   || ew_seq)   code = FC_SEQUENCE;
        else if (ns_short || ew_short) code = FC_SHORT_YELLOW;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == MON_NORMAL && code != FC_NONE)
            state_d = MON_FLASH;
    end

    assign flash_wrap = (flash_cnt_q == FW'(FLASH_HALF - 1));

    always_ff @(posedge clk) begin
        if (rst_a) state_q <= MON_NORMAL;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst_a) begin
            lamp_ns     <= 3'b100;
            lamp_ew     <= 3'b100;
            fault       <= 1'b0;
            fault_code  <= FC_NONE;
            flash_cnt_q <= '0;
            flash_on_q  <= 1'b0;
        end else if (state_q == MON_NORMAL) begin
            if (code != FC_NONE) begin
                fault       <= 1'b1;
                fault_code  <= code;
                flash_cnt_q <= '0;
                flash_on_q  <= 1'b1;
                lamp_ns     <= 3'b100;
                lamp_ew     <= 3'b100;
            end else begin
                lamp_ns <= {|red_ns, |yellow_ns, |green_ns};
                lamp_ew <= {|red_ew, |yellow_ew, |green_ew};
            end
        end else begin
            flash_cnt_q <= flash_wrap ? '0 : flash_cnt_q + FW'(1);
            flash_on_q  <= flash_on_q ^ flash_wrap;
            lamp_ns     <= {flash_on_q ^ flash_wrap, 2'b00};
            lamp_ew     <= {flash_on_q ^ flash_wrap, 2'b00};
        end
    end

endmodule

// File: tb/tb_tlc_conflict_monitor.sv
// tb/tb_tlc_conflict_monitor.sv - vector table, flash sequence and randomized model check of the monitor
module tb_tlc_conflict_monitor;

    localparam int DARK_LIMIT = 4;
    localparam int MIN_YELLOW = 3;
    localparam int FLASH_HALF = 8;

    logic       clk = 1'b0;
    logic       rst_a;
    logic [2:0] green_ns, yellow_ns, red_ns, green_ew, yellow_ew, red_ew;
    logic [2:0] lamp_ns, lamp_ew, fault_code;
    logic       fault;

    int errors = 0;
    int checks = 0;

    tlc_conflict_monitor #(.DARK_LIMIT(DARK_LIMIT), .MIN_YELLOW(MIN_YELLOW), .FLASH_HALF(FLASH_HALF)) dut (
        .clk(clk), .rst_a(rst_a),
        .green_ns(green_ns), .yellow_ns(yellow_ns), .red_ns(red_ns),
        .green_ew(green_ew), .yellow_ew(yellow_ew), .red_ew(red_ew),
        .lamp_ns(lamp_ns), .lamp_ew(lamp_ew), .fault(fault), .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic [2:0] ns;
        logic [2:0] ew;
        logic [2:0] exp_ns;
        logic [2:0] exp_ew;
        logic       exp_fault;
        logic [2:0] exp_code;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(logic r, logic [2:0] ns, logic [2:0] ew, logic [2:0] ens,
                               logic [2:0] eew, logic f, logic [2:0] c);
        vec_t t;
        t.rst = r; t.ns = ns; t.ew = ew; t.exp_ns = ens; t.exp_ew = eew;
        t.exp_fault = f; t.exp_code = c;
        return t;
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {r,y,g} lamp pattern to selects; 'on' is any nonzero select value.
    task automatic drive(input logic r, input logic [2:0] ns, input logic [2:0] ew, input logic [2:0] on);
        rst_a     = r;
        green_ns  = ns[0] ? on : 3'd0;
        yellow_ns = ns[1] ? on : 3'd0;
        red_ns    = ns[2] ? on : 3'd0;
        green_ew  = ew[0] ? on : 3'd0;
        yellow_ew = ew[1] ? on : 3'd0;
        red_ew    = ew[2] ? on : 3'd0;
    endtask

    // Reference model: aspects as 0 off, 1 G, 2 Y, 3 R, 4 multi; index 0 = NS, 1 = EW.
    int  m_last[2], m_dark[2], m_yrun[2];
    bit  m_fault;
    int  m_code, m_k;
    logic [2:0] m_lamp[2];

    function automatic int asp_of(logic [2:0] g, logic [2:0] y, logic [2:0] r);
        int n;
        n = int'(g != 0) + int'(y != 0) + int'(r != 0);
        if (n == 0) return 0;
        if (n > 1) return 4;
        if (g != 0) return 1;
        if (y != 0) return 2;
        return 3;
    endfunction

    task automatic model_step();
        int asp[2];
        bit fc[6];
        logic [2:0] g[2], y[2], r[2];
        if (rst_a) begin
            for (int a = 0; a < 2; a++) begin
                m_last[a] = 3; m_dark[a] = 0; m_yrun[a] = 0; m_lamp[a] = 3'b100;
            end
            m_fault = 0; m_code = 0; m_k = 0;
            return;
        end
        if (m_fault) begin
            m_k++;
            m_lamp[0] = (((m_k / FLASH_HALF) % 2) == 0) ? 3'b100 : 3'b000;
            m_lamp[1] = m_lamp[0];
            return;
        end
        g[0] = green_ns; y[0] = yellow_ns; r[0] = red_ns;
        g[1] = green_ew; y[1] = yellow_ew; r[1] = red_ew;
        for (int i = 0; i < 6; i++) fc[i] = 0;
        fc[1] = ((g[0] != 0) || (y[0] != 0)) && ((g[1] != 0) || (y[1] != 0));
        for (int a = 0; a < 2; a++) begin
            asp[a] = asp_of(g[a], y[a], r[a]);
            if (asp[a] == 4) fc[2] = 1;
            if (asp[a] == 0 && m_dark[a] + 1 >= DARK_LIMIT) fc[3] = 1;
            if (asp[a] >= 1 && asp[a] <= 3 && asp[a] != m_last[a] && (m_last[a] % 3) + 1 != asp[a])
                fc[4] = 1;
            if (m_last[a] == 2 && asp[a] == 3 && m_yrun[a] < MIN_YELLOW) fc[5] = 1;
        end
        m_code = 0;
        for (int i = 5; i >= 1; i--) if (fc[i]) m_code = i;
        for (int a = 0; a < 2; a++) begin
            m_dark[a] = (asp[a] == 0) ? m_dark[a] + 1 : 0;
            if (asp[a] == 2) m_yrun[a] = (m_last[a] == 2) ? m_yrun[a] + 1 : 1;
            if (asp[a] >= 1 && asp[a] <= 3) m_last[a] = asp[a];
            m_lamp[a] = {r[a] != 0, y[a] != 0, g[a] != 0};
        end
        if (m_code != 0) begin
            m_fault = 1; m_k = 0;
            m_lamp[0] = 3'b100; m_lamp[1] = 3'b100;
        end
    endtask

    localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001, O = 3'b000;

    int phase, remain, flash_left;
    logic [2:0] gen_ns, gen_ew;

    initial begin
        drive(1'b1, R, R, 3'd1);
        tick();
        check("reset_lamp_ns", lamp_ns, 3'b100);
        check("reset_lamp_ew", lamp_ew, 3'b100);
        check("reset_fault", fault, 0);
        check("reset_code", fault_code, 0);

        vecs.push_back(v(1, R, R, R, R, 0, 0));
        vecs.push_back(v(0, G, R, G, R, 0, 0));
        vecs.push_back(v(0, Y, R, Y, R, 0, 0));
        vecs.push_back(v(0, Y, R, Y, R, 0, 0));
        vecs.push_back(v(0, Y, R, Y, R, 0, 0));
        vecs.push_back(v(0, R, R, R, R, 0, 0));
        vecs.push_back(v(0, R, G, R, G, 0, 0));
        vecs.push_back(v(0, R, R, R, R, 1, 4));
        vecs.push_back(v(0, G, G, R, R, 1, 4));
        vecs.push_back(v(1, R, R, R, R, 0, 0));
        vecs.push_back(v(0, G, R, G, R, 0, 0));
        vecs.push_back(v(0, Y, R, Y, R, 0, 0));
        vecs.push_back(v(0, Y, R, Y, R, 0, 0));
        vecs.push_back(v(0, R, R, R, R, 1, 5));
        vecs.push_back(v(1, R, R, R, R, 0, 0));
        vecs.push_back(v(0, G, 3'b101, R, R, 1, 1));
        vecs.push_back(v(1, R, R, R, R, 0, 0));
        vecs.push_back(v(0, O, R, O, R, 0, 0));
        vecs.push_back(v(0, O, R, O, R, 0, 0));
        vecs.push_back(v(0, O, R, O, R, 0, 0));
        vecs.push_back(v(0, R, R, R, R, 0, 0));
        vecs.push_back(v(0, O, R, O, R, 0, 0));
        vecs.push_back(v(0, O, R, O, R, 0, 0));
        vecs.push_back(v(0, O, R, O, R, 0, 0));
        vecs.push_back(v(0, O, R, R, R, 1, 3));
        vecs.push_back(v(1, R, R, R, R, 0, 0));
        vecs.push_back(v(0, G, R, G, R, 0, 0));
        vecs.push_back(v(0, O, R, O, R, 0, 0));
        vecs.push_back(v(0, O, R, O, R, 0, 0));
        vecs.push_back(v(0, R, R, R, R, 1, 4));
        vecs.push_back(v(1, R, R, R, R, 0, 0));
        vecs.push_back(v(0, G, R, G, R, 0, 0));
        vecs.push_back(v(0, R, R, R, R, 1, 4));
        vecs.push_back(v(1, R, R, R, R, 0, 0));
        vecs.push_back(v(0, 3'b011, R, R, R, 1, 2));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].ns, vecs[i].ew, 3'(1 + (i % 7)));
            tick();
            check($sformatf("vec%0d_lamp_ns", i), lamp_ns, vecs[i].exp_ns);
            check($sformatf("vec%0d_lamp_ew", i), lamp_ew, vecs[i].exp_ew);
            check($sformatf("vec%0d_fault", i), fault, vecs[i].exp_fault);
            check($sformatf("vec%0d_code", i), fault_code, vecs[i].exp_code);
        end

        // Conflict after ten quiet cycles, then the flash cadence and a mid-flash reset.
        drive(1'b1, R, R, 3'd1);
        tick();
        for (int c = 0; c < 10; c++) begin
            drive(1'b0, R, R, 3'd1);
            tick();
        end
        check("quiet_fault", fault, 0);
        drive(1'b0, G, G, 3'd1);
        tick();
        check("conf_fault", fault, 1);
        check("conf_code", fault_code, 1);
        check("conf_lamp_ns", lamp_ns, 3'b100);
        check("conf_lamp_ew", lamp_ew, 3'b100);
        for (int k = 1; k < 52; k++) begin
            drive(1'b0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(1, 7)));
            tick();
            check($sformatf("flash%0d_ns", k), lamp_ns, ((k / 8) % 2 == 0) ? 3'b100 : 3'b000);
            check($sformatf("flash%0d_ew", k), lamp_ew, ((k / 8) % 2 == 0) ? 3'b100 : 3'b000);
            check($sformatf("flash%0d_code", k), fault_code, 1);
        end
        drive(1'b1, G, G, 3'd1);
        tick();
        check("midflash_rst_fault", fault, 0);
        check("midflash_rst_code", fault_code, 0);
        check("midflash_rst_lamp_ns", lamp_ns, 3'b100);
        check("midflash_rst_lamp_ew", lamp_ew, 3'b100);

        // Sequencer-like legal traffic with occasional corruption, checked against the model.
        model_step();
        phase = 0; remain = 8; flash_left = 0;
        for (int c = 0; c < 4000; c++) begin
            case (phase)
                0: begin gen_ns = G; gen_ew = R; end
                1: begin gen_ns = Y; gen_ew = R; end
                2: begin gen_ns = R; gen_ew = R; end
                3: begin gen_ns = R; gen_ew = G; end
                4: begin gen_ns = R; gen_ew = Y; end
                default: begin gen_ns = R; gen_ew = R; end
            endcase
            drive(1'b0, gen_ns, gen_ew, 3'($urandom_range(1, 7)));
            if ($urandom_range(0, 29) == 0) begin
                green_ns = 3'd0; yellow_ns = 3'd0; red_ns = 3'd0;
            end
            if ($urandom_range(0, 59) == 0) begin
                green_ns = 3'($urandom_range(0, 7)); yellow_ns = 3'($urandom_range(0, 7));
                red_ns = 3'($urandom_range(0, 7)); green_ew = 3'($urandom_range(0, 7));
                yellow_ew = 3'($urandom_range(0, 7)); red_ew = 3'($urandom_range(0, 7));
            end
            if ((m_fault && flash_left == 0) || $urandom_range(0, 499) == 0) begin
                rst_a = 1'b1;
                phase = 0; remain = $urandom_range(4, 12);
            end else begin
                remain--;
                if (remain <= 0) begin
                    phase = (phase + 1) % 6;
                    case (phase)
                        1, 4:    remain = $urandom_range(2, 5);
                        2, 5:    remain = $urandom_range(1, 2);
                        default: remain = $urandom_range(4, 14);
                    endcase
                end
            end
            model_step();
            if (m_fault && flash_left == 0 && !rst_a) flash_left = $urandom_range(10, 40);
            else if (flash_left > 0) flash_left--;
            if (rst_a) flash_left = 0;
            tick();
            check("rand_lamp_ns", lamp_ns, m_lamp[0]);
            check("rand_lamp_ew", lamp_ew, m_lamp[1]);
            check("rand_fault", fault, m_fault);
            check("rand_code", fault_code, m_code);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
